// File: rtl/bpsk_demodulator_if.sv
// bpsk_demodulator_if
// Sample-path bundle between the transceiver front end and the BPSK receiver.
//   en          sample strobe
//   signal_in   received sample, offset-binary
//   sine_ref_in reference sine sample, offset-binary, phase-aligned with signal_in
//   cnt_in      reference sample index inside the current symbol
//   bit_out     most recent decided bit      (bit_valid strobes an update)
//   data_out    most recent assembled word   (data_valid strobes an update)
//   locked      receiver is symbol-aligned
// master: sample source / result consumer. slave: the demodulator.
interface bpsk_demodulator_if #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int DATA_WIDTH    = 12
);
  localparam int CW = $clog2(SAMPLE_NUMBER);

  logic                    en;
  logic [SAMPLE_WIDTH-1:0] signal_in;
  logic [SAMPLE_WIDTH-1:0] sine_ref_in;
  logic [CW-1:0]           cnt_in;
  logic                    bit_out;
  logic                    bit_valid;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    data_valid;
  logic                    locked;

  modport master (
    output en, signal_in, sine_ref_in, cnt_in,
    input  bit_out, bit_valid, data_out, data_valid, locked
  );

  modport slave (
    input  en, signal_in, sine_ref_in, cnt_in,
    output bit_out, bit_valid, data_out, data_valid, locked
  );
endinterface

// File: rtl/bpsk_demodulator.sv
// bpsk_demodulator
// Coherent BPSK receiver. Each symbol's samples are multiplied by the shared
// sine reference and summed; the sign of the sum is the bit. Bits are packed
// LSB-first into DATA_WIDTH-bit words.
// Ports:
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  bpsk_demodulator_if.slave (sample inputs, bit/word outputs, locked)
//
// state | meaning
// IDLE  | waiting for a cnt_in==0 sample to align to a symbol boundary
// RUN   | aligned; every en sample is accumulated, bits/words are emitted
module bpsk_demodulator #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int DATA_WIDTH    = 12
) (
  input logic                 clk,
  input logic                 rst,
  bpsk_demodulator_if.slave   bus
);
  localparam int CW = $clog2(SAMPLE_NUMBER);
  localparam int PW = 2 * SAMPLE_WIDTH;
  localparam int AW = PW + CW;
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                         r_state;
  logic signed [SAMPLE_WIDTH-1:0] r_s0_s, r_s0_r;
  logic                           r_s0_last, r_s0_valid;
  logic signed [PW-1:0]           r_s1_p;
  logic                           r_s1_last, r_s1_valid;
  logic signed [AW-1:0]           r_acc;
  logic [DATA_WIDTH-1:0]          r_word;
  logic [BW-1:0]                  r_bit_cnt;
  logic                           r_bit_out, r_bit_valid;
  logic [DATA_WIDTH-1:0]          r_data_out;
  logic                           r_data_valid;

  logic signed [SAMPLE_WIDTH-1:0] w_s, w_r;
  logic                           w_accept, w_last;
  logic signed [PW-1:0]           w_prod;
  logic signed [AW-1:0]           w_sum;
  logic                           w_bit;

  // Offset-binary to two's complement: flip the MSB.
  assign w_s = {~bus.signal_in[SAMPLE_WIDTH-1],   bus.signal_in[SAMPLE_WIDTH-2:0]};
  assign w_r = {~bus.sine_ref_in[SAMPLE_WIDTH-1], bus.sine_ref_in[SAMPLE_WIDTH-2:0]};

  // While IDLE only a symbol-start sample is taken; that same sample opens RUN.
  assign w_accept = bus.en && ((r_state == RUN) || (bus.cnt_in == '0));
  assign w_last   = (bus.cnt_in == CW'(SAMPLE_NUMBER - 1));

  assign w_prod = PW'(r_s0_s) * PW'(r_s0_r);
  assign w_sum  = r_acc + AW'(r_s1_p);
  // Strictly positive correlation decides 1; a zero sum is a 0.
  assign w_bit  = ~w_sum[AW-1] & (|w_sum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_s0_s       <= '0;
      r_s0_r       <= '0;
      r_s0_last    <= 1'b0;
      r_s0_valid   <= 1'b0;
      r_s1_p       <= '0;
      r_s1_last    <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_acc        <= '0;
      r_word       <= '0;
      r_bit_cnt    <= '0;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_bit_valid  <= 1'b0;
      r_data_valid <= 1'b0;

      if (r_state == IDLE && w_accept) r_state <= RUN;

      r_s0_s     <= w_s;
      r_s0_r     <= w_r;
      r_s0_last  <= w_last;
      r_s0_valid <= w_accept;

      // S1/S2 run every clock; en gaps travel as cleared valid bits.
      r_s1_p     <= w_prod;
      r_s1_last  <= r_s0_last;
      r_s1_valid <= r_s0_valid;

      if (r_s1_valid) begin
        if (!r_s1_last) begin
          r_acc <= w_sum;
        end else begin
          r_acc             <= '0;
          r_bit_out         <= w_bit;
          r_bit_valid       <= 1'b1;
          r_word[r_bit_cnt] <= w_bit;
          if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
            r_data_out   <= {w_bit, r_word[DATA_WIDTH-2:0]};
            r_data_valid <= 1'b1;
            r_bit_cnt    <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
      end
    end
  end

  assign bus.bit_out    = r_bit_out;
  assign bus.bit_valid  = r_bit_valid;
  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.locked     = (r_state == RUN);
endmodule

// File: tb/tb_bpsk_demodulator.sv
// tb_bpsk_demodulator
// Two receivers: a 4-sample-per-symbol instance for lock, slicing, words,
// en gaps and reset; a default 256-sample instance for full-scale sums.
// Expected bits come from a plain-arithmetic correlation of the stimulus.
module tb_bpsk_demodulator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bpsk_demodulator_if #(.SAMPLE_NUMBER(4), .SAMPLE_WIDTH(12), .DATA_WIDTH(12)) bus4();
  bpsk_demodulator #(.SAMPLE_NUMBER(4), .SAMPLE_WIDTH(12), .DATA_WIDTH(12)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));

  bpsk_demodulator_if #(.SAMPLE_NUMBER(256), .SAMPLE_WIDTH(12), .DATA_WIDTH(12)) bus256();
  bpsk_demodulator #(.SAMPLE_NUMBER(256), .SAMPLE_WIDTH(12), .DATA_WIDTH(12)) dut256 (
    .clk(clk), .rst(rst), .bus(bus256.slave));

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int sref4[4] = '{2048, 4095, 2048, 1};

  int bit_q[$];
  int bit_edge_q[$];
  int word_q[$];
  int word_edge_q[$];
  int bit256_q[$];
  int exp_bits[$];
  int exp256[$];
  int bad_strobe = 0;
  logic prev_bv = 1'b0;
  logic prev_dv = 1'b0;

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (bus4.bit_valid) begin
      bit_q.push_back(int'(bus4.bit_out));
      bit_edge_q.push_back(edge_cnt);
    end
    if (bus4.data_valid) begin
      word_q.push_back(int'(bus4.data_out));
      word_edge_q.push_back(edge_cnt);
    end
    if ((bus4.bit_valid || bus4.data_valid) && !bus4.locked) bad_strobe++;
    if ((bus4.bit_valid && prev_bv) || (bus4.data_valid && prev_dv)) bad_strobe++;
    prev_bv = bus4.bit_valid;
    prev_dv = bus4.data_valid;
    if (bus256.bit_valid) bit256_q.push_back(int'(bus256.bit_out));
  end

  task automatic drv4(input logic en, input int sig, input int rf, input int cnt);
    @(negedge clk);
    bus4.en          = en;
    bus4.signal_in   = 12'(sig);
    bus4.sine_ref_in = 12'(rf);
    bus4.cnt_in      = 2'(cnt);
  endtask

  task automatic idle4(input int n);
    repeat (n) drv4(1'b0, 0, 0, 0);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    bus4.en = 1'b0; bus4.signal_in = '0; bus4.sine_ref_in = '0; bus4.cnt_in = '0;
    bus256.en = 1'b0; bus256.signal_in = '0; bus256.sine_ref_in = '0; bus256.cnt_in = '0;
    repeat (2) @(posedge clk);
    bit_q.delete(); bit_edge_q.delete(); word_q.delete(); word_edge_q.delete();
    bit256_q.delete(); exp_bits.delete(); exp256.delete();
    bad_strobe = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One symbol on the 4-sample instance; expected bit is the sign of the
  // correlation of signed sample and signed reference.
  task automatic send_symbol4(input int sig[4], input bit gaps, output int k_last);
    longint sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0)
          drv4(1'b0, $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 3));
      drv4(1'b1, sig[i], sref4[i], i);
      sum += longint'(sig[i] - 2048) * longint'(sref4[i] - 2048);
    end
    k_last = edge_cnt + 1;
    exp_bits.push_back(sum > 0 ? 1 : 0);
  endtask

  task automatic send_mod_bit(input bit b, input bit gaps);
    int sig[4];
    int k;
    for (int i = 0; i < 4; i++) sig[i] = b ? sref4[i] : 4096 - sref4[i];
    send_symbol4(sig, gaps, k);
  endtask

  function automatic int pack_word(input int base);
    int w = 0;
    for (int i = 0; i < 12; i++) w |= (exp_bits[base + i] & 1) << i;
    return w;
  endfunction

  task automatic test_reset;
    do_reset;
    checks++; if (bus4.bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out: got %0b expected 0", bus4.bit_out); end
    checks++; if (bus4.bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid: got %0b expected 0", bus4.bit_valid); end
    checks++; if (bus4.data_out !== 12'h000) begin errors++; $display("FAIL reset_data_out: got %0h expected 0", bus4.data_out); end
    checks++; if (bus4.data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %0b expected 0", bus4.data_valid); end
    checks++; if (bus4.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", bus4.locked); end
    checks++; if (bus256.locked !== 1'b0) begin errors++; $display("FAIL reset_locked256: got %0b expected 0", bus256.locked); end
  endtask

  task automatic test_lock;
    do_reset;
    drv4(1'b1, 2048, 2048, 2);
    drv4(1'b1, 1, 4095, 3);
    drv4(1'b1, 2048, 2048, 0);
    checks++; if (bus4.locked !== 1'b0) begin errors++; $display("FAIL lock_before_cnt0: got %0b expected 0", bus4.locked); end
    drv4(1'b1, 4095, 4095, 1);
    checks++; if (bus4.locked !== 1'b1) begin errors++; $display("FAIL lock_at_cnt0: got %0b expected 1", bus4.locked); end
    checks++; if (bit_q.size() != 0) begin errors++; $display("FAIL lock_no_early_strobe: got %0d strobes expected 0", bit_q.size()); end
    drv4(1'b1, 2048, 2048, 2);
    drv4(1'b1, 1, 1, 3);
    idle4(4);
    checks++;
    if (bit_q.size() != 1 || bit_q[0] != 1) begin
      errors++; $display("FAIL lock_first_bit: got %0d bits (first %0d) expected 1 bit of 1", bit_q.size(), bit_q.size() ? bit_q[0] : -1);
    end
  endtask

  task automatic test_bit_slicing;
    int sig_p[4] = '{2048, 4095, 2048, 1};
    int sig_n[4] = '{2048, 1, 2048, 4095};
    int k1, k2;
    do_reset;
    send_symbol4(sig_p, 1'b0, k1);
    send_symbol4(sig_n, 1'b0, k2);
    idle4(4);
    checks++;
    if (bit_q.size() != 2) begin
      errors++; $display("FAIL slice_count: got %0d expected 2", bit_q.size());
    end else begin
      checks++; if (bit_q[0] != exp_bits[0]) begin errors++; $display("FAIL slice_pos: got %0d expected %0d", bit_q[0], exp_bits[0]); end
      checks++; if (bit_q[1] != exp_bits[1]) begin errors++; $display("FAIL slice_neg: got %0d expected %0d", bit_q[1], exp_bits[1]); end
      checks++; if (bit_edge_q[0] != k1 + 2) begin errors++; $display("FAIL slice_latency0: got edge %0d expected %0d", bit_edge_q[0], k1 + 2); end
      checks++; if (bit_edge_q[1] != k2 + 2) begin errors++; $display("FAIL slice_latency1: got edge %0d expected %0d", bit_edge_q[1], k2 + 2); end
    end
  endtask

  task automatic test_word_assembly;
    int words[2] = '{12'hA5C, 12'h3F1};
    do_reset;
    for (int w = 0; w < 2; w++)
      for (int b = 0; b < 12; b++) send_mod_bit(1'((words[w] >> b) & 1), 1'b0);
    idle4(4);
    checks++;
    if (word_q.size() != 2 || bit_q.size() != 24) begin
      errors++; $display("FAIL word_count: got %0d words %0d bits expected 2 words 24 bits", word_q.size(), bit_q.size());
    end else begin
      checks++; if (word_q[0] != words[0]) begin errors++; $display("FAIL word0: got %03h expected %03h", word_q[0], words[0]); end
      checks++; if (word_q[1] != words[1]) begin errors++; $display("FAIL word1: got %03h expected %03h", word_q[1], words[1]); end
      checks++; if (word_edge_q[1] - word_edge_q[0] != 48) begin errors++; $display("FAIL word_spacing: got %0d expected 48", word_edge_q[1] - word_edge_q[0]); end
      checks++; if (word_edge_q[0] != bit_edge_q[11]) begin errors++; $display("FAIL word_with_bit: got edge %0d expected %0d", word_edge_q[0], bit_edge_q[11]); end
    end
    checks++; if (bad_strobe != 0) begin errors++; $display("FAIL word_strobe_shape: got %0d bad strobes expected 0", bad_strobe); end
  endtask

  task automatic test_tie;
    int sig[4] = '{2048, 2048, 2048, 2048};
    int k;
    do_reset;
    repeat (3) send_symbol4(sig, 1'b0, k);
    idle4(4);
    checks++;
    if (bit_q.size() != 3) begin
      errors++; $display("FAIL tie_count: got %0d expected 3", bit_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (bit_q[i] != exp_bits[i]) begin errors++; $display("FAIL tie_bit%0d: got %0d expected %0d", i, bit_q[i], exp_bits[i]); end
      end
    end
  endtask

  task automatic test_en_gaps;
    int sig[4];
    int k;
    do_reset;
    for (int s = 0; s < 24; s++) begin
      for (int i = 0; i < 4; i++) sig[i] = $urandom_range(0, 4095);
      send_symbol4(sig, 1'b1, k);
    end
    idle4(4);
    checks++;
    if (bit_q.size() != 24 || word_q.size() != 2) begin
      errors++; $display("FAIL gaps_count: got %0d bits %0d words expected 24 bits 2 words", bit_q.size(), word_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++; if (bit_q[i] != exp_bits[i]) begin errors++; $display("FAIL gaps_bit%0d: got %0d expected %0d", i, bit_q[i], exp_bits[i]); end
      end
      for (int w = 0; w < 2; w++) begin
        checks++; if (word_q[w] != pack_word(12 * w)) begin errors++; $display("FAIL gaps_word%0d: got %03h expected %03h", w, word_q[w], pack_word(12 * w)); end
      end
    end
    checks++; if (bad_strobe != 0) begin errors++; $display("FAIL gaps_strobe_shape: got %0d bad strobes expected 0", bad_strobe); end
  endtask

  task automatic test_reset_mid_word;
    int word;
    do_reset;
    for (int b = 0; b < 5; b++) send_mod_bit(1'($urandom_range(0, 1)), 1'b0);
    idle4(4);
    checks++; if (bit_q.size() != 5) begin errors++; $display("FAIL midrst_pre_bits: got %0d expected 5", bit_q.size()); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus4.locked !== 1'b0) begin errors++; $display("FAIL midrst_locked: got %0b expected 0", bus4.locked); end
    checks++; if (bus4.bit_out !== 1'b0) begin errors++; $display("FAIL midrst_bit_out: got %0b expected 0", bus4.bit_out); end
    checks++; if (bus4.data_out !== 12'h000) begin errors++; $display("FAIL midrst_data_out: got %0h expected 0", bus4.data_out); end
    @(posedge clk);
    bit_q.delete(); bit_edge_q.delete(); word_q.delete(); word_edge_q.delete(); exp_bits.delete();
    @(negedge clk);
    rst = 1'b1;
    drv4(1'b1, 4095, 4095, 1);
    drv4(1'b1, 2048, 2048, 2);
    drv4(1'b1, 1, 1, 3);
    idle4(1);
    checks++; if (bus4.locked !== 1'b0) begin errors++; $display("FAIL midrst_no_lock_midsymbol: got %0b expected 0", bus4.locked); end
    word = $urandom_range(0, 4095);
    for (int b = 0; b < 12; b++) send_mod_bit(1'((word >> b) & 1), 1'b0);
    idle4(4);
    checks++;
    if (word_q.size() != 1) begin
      errors++; $display("FAIL midrst_word_count: got %0d expected 1", word_q.size());
    end else if (word_q[0] != word) begin
      errors++; $display("FAIL midrst_word: got %03h expected %03h", word_q[0], word);
    end
  endtask

  task automatic test_full_scale;
    int sig, rf;
    longint sum;
    do_reset;
    for (int s = 0; s < 3; s++) begin
      sum = 0;
      for (int i = 0; i < 256; i++) begin
        case (s)
          0: begin rf = (i < 128) ? 4095 : 0; sig = rf; end
          1: begin rf = (i < 128) ? 4095 : 0; sig = 4095 - rf; end
          default: begin rf = 0; sig = 0; end
        endcase
        @(negedge clk);
        bus256.en = 1'b1;
        bus256.signal_in = 12'(sig);
        bus256.sine_ref_in = 12'(rf);
        bus256.cnt_in = 8'(i);
        sum += longint'(sig - 2048) * longint'(rf - 2048);
      end
      exp256.push_back(sum > 0 ? 1 : 0);
    end
    @(negedge clk);
    bus256.en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bit256_q.size() != 3) begin
      errors++; $display("FAIL full_count: got %0d expected 3", bit256_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (bit256_q[i] != exp256[i]) begin errors++; $display("FAIL full_bit%0d: got %0d expected %0d", i, bit256_q[i], exp256[i]); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_bit_slicing;
    test_word_assembly;
    test_tie;
    test_en_gaps;
    test_reset_mid_word;
    test_full_scale;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
